// File: rtl/cmd_dispatch.sv
// cmd_dispatch: command FIFO that issues sprite commands one per cycle and
// holds flush commands until vertical blanking, at most one flush per frame.
module cmd_dispatch #(
   parameter int         DEPTH        = 16,
   parameter logic [9:0] VBLANK_START = 10'd480
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     chipselect,
   input  logic                     write,
   input  logic [31:0]              writedata,
   input  logic [9:0]               vcount,
   output logic [31:0]              cmd_out,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic [7:0]               flush_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] RUN        = 2'd0;
   localparam logic [1:0] WAIT_VB    = 2'd1;
   localparam logic [1:0] POST_FLUSH = 2'd2;
   logic [31:0] r_mem [DEPTH];
   logic [AW-1:0] r_rd, r_wr;
   logic [AW:0] r_count;
   logic [1:0] r_state, w_next;
   logic [31:0] r_cmd, w_head;
   logic r_ovf, w_full, w_empty, w_hflush, w_vb, w_wr, w_push, w_pop;
   logic [7:0] r_flush;
   // DEPTH is a power of two, so the count MSB alone marks a full FIFO
   assign w_full   = r_count[AW];
   assign w_empty  = r_count == '0;
   assign w_head   = r_mem[r_rd];
   assign w_hflush = w_head[20:17] == 4'hF;
   assign w_vb     = vcount >= VBLANK_START;
   assign w_wr     = chipselect & write;
   assign w_push   = w_wr & ~w_full;
   always_comb begin
      w_pop  = (r_state == WAIT_VB) ? (w_vb & ~w_empty) : (~w_empty & ~w_hflush);
      w_next = (r_state == RUN)     ? ((~w_empty & w_hflush) ? WAIT_VB : RUN) :
               (r_state == WAIT_VB) ? (w_pop ? POST_FLUSH : WAIT_VB) :
               (w_vb ? POST_FLUSH : RUN);
   end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr] <= writedata;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_state <= RUN;
         r_cmd   <= '0;
         r_ovf   <= 1'b0;
         r_flush <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_state <= w_next;
         r_cmd   <= w_pop ? w_head : 32'h0;
         if (w_wr & w_full) r_ovf <= 1'b1;
         if (r_state == WAIT_VB && w_pop) r_flush <= r_flush + 8'd1;
      end
   end
   assign cmd_out     = r_cmd;
   assign fifo_count  = r_count;
   assign overflow    = r_ovf;
   assign flush_count = r_flush;
endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: directed vectors with hand-computed expectations for cmd_dispatch.
module tb_cmd_dispatch;
   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect;
   logic        write;
   logic [31:0] writedata;
   logic [9:0]  vcount;
   logic [31:0] cmd_out;
   logic [4:0]  fifo_count;
   logic        overflow;
   logic [7:0]  flush_count;
   int n_checks = 0;
   int n_errors = 0;
   cmd_dispatch #(.DEPTH(16), .VBLANK_START(10'd480)) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
      .writedata(writedata), .vcount(vcount), .cmd_out(cmd_out),
      .fifo_count(fifo_count), .overflow(overflow), .flush_count(flush_count)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic push(input logic [31:0] w);
      chipselect = 1'b1;
      write      = 1'b1;
      writedata  = w;
      tick();
      chipselect = 1'b0;
      write      = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      reset = 1'b1; chipselect = 1'b0; write = 1'b0; writedata = '0; vcount = 10'd100;
      @(negedge clk);
      tick();
      tick();
      check("rst_cmd", cmd_out, 32'h0);
      check("rst_cnt", 32'(fifo_count), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_flush", 32'(flush_count), 32'd0);
      reset = 1'b0;
      // single normal word: latency one cycle, then back to no-op
      push(32'h14020005);
      check("lat_cnt1", 32'(fifo_count), 32'd1);
      check("lat_cmd0", cmd_out, 32'h0);
      tick();
      check("lat_cmd1", cmd_out, 32'h14020005);
      check("lat_cnt0", 32'(fifo_count), 32'd0);
      tick();
      check("lat_cmd2", cmd_out, 32'h0);
      // flush waits for blanking, normal word follows
      push(32'h001E2000);
      push(32'h14020011);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fl_hold", cmd_out, 32'h0);
         check("fl_hold_cnt", 32'(fifo_count), 32'd2);
      end
      vcount = 10'd480;
      tick();
      check("fl_issue", cmd_out, 32'h001E2000);
      check("fl_count1", 32'(flush_count), 32'd1);
      tick();
      check("fl_next", cmd_out, 32'h14020011);
      check("fl_empty", 32'(fifo_count), 32'd0);
      vcount = 10'd0;
      tick();
      check("fl_idle", cmd_out, 32'h0);
      // two flushes: one per frame
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vcount = 10'd470;
      push(32'h001E0001);
      push(32'h001E0002);
      tick();
      check("ff_wait", cmd_out, 32'h0);
      vcount = 10'd480;
      tick();
      check("ff_first", cmd_out, 32'h001E0001);
      vcount = 10'd500;
      tick();
      check("ff_stall1", cmd_out, 32'h0);
      tick();
      check("ff_stall2", cmd_out, 32'h0);
      check("ff_stall_cnt", 32'(fifo_count), 32'd1);
      vcount = 10'd0;
      tick();
      check("ff_run", cmd_out, 32'h0);
      tick();
      check("ff_wait2", cmd_out, 32'h0);
      vcount = 10'd300;
      tick();
      check("ff_wait3", cmd_out, 32'h0);
      vcount = 10'd480;
      tick();
      check("ff_second", cmd_out, 32'h001E0002);
      check("ff_count2", 32'(flush_count), 32'd2);
      vcount = 10'd0;
      tick();
      // fill behind a pending flush; overflowing write coincides with the flush pop
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vcount = 10'd100;
      push(32'h001E0003);
      for (int i = 0; i < 15; i++) push(32'h14020100 + 32'(i));
      check("of_full", 32'(fifo_count), 32'd16);
      check("of_clear", 32'(overflow), 32'd0);
      vcount = 10'd480;
      push(32'h140201FF);
      check("of_flush", cmd_out, 32'h001E0003);
      check("of_cnt15", 32'(fifo_count), 32'd15);
      check("of_set", 32'(overflow), 32'd1);
      for (int i = 0; i < 15; i++) begin
         tick();
         check("of_drain", cmd_out, 32'h14020100 + 32'(i));
      end
      tick();
      check("of_dropped", cmd_out, 32'h0);
      check("of_cnt0", 32'(fifo_count), 32'd0);
      check("of_sticky", 32'(overflow), 32'd1);
      vcount = 10'd0;
      tick();
      // reset while a flush is pending in WAIT_VB
      vcount = 10'd100;
      push(32'h001E0004);
      for (int i = 0; i < 4; i++) push(32'h14020300 + 32'(i));
      check("rw_cnt5", 32'(fifo_count), 32'd5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rw_cnt", 32'(fifo_count), 32'd0);
      check("rw_cmd", cmd_out, 32'h0);
      check("rw_ovf", 32'(overflow), 32'd0);
      vcount = 10'd480;
      tick();
      check("rw_none1", cmd_out, 32'h0);
      tick();
      check("rw_none2", cmd_out, 32'h0);
      check("rw_flush", 32'(flush_count), 32'd0);
      vcount = 10'd0;
      tick();
      // steady push+pop at depth 3 across pointer wrap
      vcount = 10'd100;
      push(32'h001E0005);
      push(32'h14020201);
      push(32'h14020202);
      check("wr_cnt3", 32'(fifo_count), 32'd3);
      vcount = 10'd480;
      for (int k = 3; k <= 20; k++) begin
         push(32'h14020200 + 32'(k));
         check("wr_order", cmd_out, (k == 3) ? 32'h001E0005 : 32'h14020200 + 32'(k - 3));
         check("wr_cnt", 32'(fifo_count), 32'd3);
      end
      for (int k = 18; k <= 20; k++) begin
         tick();
         check("wr_tail", cmd_out, 32'h14020200 + 32'(k));
         check("wr_tail_cnt", 32'(fifo_count), 32'(20 - k));
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
